// File: rtl/punct_pkg.sv
// Shared definitions for the 802.11a convolutional-code puncturer.
// Holds the rate encodings, the puncturer FSM state type and the
// puncture-pattern period for each rate.
package punct_pkg;

    // Rate select encodings; 2'b11 is reserved and handled like rate 1/2.
    localparam logic [1:0] RATE_1_2 = 2'b00;
    localparam logic [1:0] RATE_2_3 = 2'b01;
    localparam logic [1:0] RATE_3_4 = 2'b10;

    // Number of encoder pairs in one puncture period.
    localparam logic [1:0] PERIOD_1_2 = 2'd1;
    localparam logic [1:0] PERIOD_2_3 = 2'd2;
    localparam logic [1:0] PERIOD_3_4 = 2'd3;

    // Phase counter width, wide enough for the longest period.
    localparam int PHASE_W = 2;

    // Puncturer control states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_LOAD   = 3'd2,
        ST_EMIT_A = 3'd3,
        ST_EMIT_B = 3'd4,
        ST_ADV    = 3'd5
    } state_t;

    // Period length for a rate code; reserved code falls back to rate 1/2.
    function automatic logic [1:0] rate_period(input logic [1:0] rate);
        logic [1:0] period;
        case (rate)
            RATE_2_3: period = PERIOD_2_3;
            RATE_3_4: period = PERIOD_3_4;
            default:  period = PERIOD_1_2;
        endcase
        return period;
    endfunction

endpackage

// File: rtl/punct_mask.sv
// Combinational puncture-pattern lookup.
// Maps (rate, phase) to which of the two encoder bits {A,B} are kept and
// whether this phase is the final one of the puncture period.
module punct_mask
    import punct_pkg::*;
(
    input  logic [1:0]         i_rate,
    input  logic [PHASE_W-1:0] i_phase,
    output logic               o_keep_a,
    output logic               o_keep_b,
    output logic               o_last_phase
);

    logic [1:0] w_period;

    // Pattern table: 1/2 = {11}; 2/3 = {11,10}; 3/4 = {11,10,01}.
    always_comb begin
        w_period = rate_period(i_rate);
        o_keep_a = 1'b1;
        o_keep_b = 1'b1;
        case (i_rate)
            RATE_2_3: begin
                if (i_phase == 2'd1) begin
                    o_keep_b = 1'b0;
                end
            end
            RATE_3_4: begin
                case (i_phase)
                    2'd1:    o_keep_b = 1'b0;
                    2'd2:    o_keep_a = 1'b0;
                    default: ;
                endcase
            end
            default: ;
        endcase
        // ">=" so an out-of-range phase still wraps back to zero.
        o_last_phase = (i_phase >= (w_period - 2'd1));
    end

endmodule

// File: rtl/conv_puncturer.sv
// 802.11a puncturer: pops rate-1/2 encoder pairs {A,B} from the encoder
// FIFO, drops bits according to the selected rate (1/2, 2/3, 3/4) and
// serialises the kept bits over a valid/ready interface.
//
// Optional build macro PUNCT_STATS_EN adds o_dropped_cnt, a saturating
// count of punctured bits. Without it the port and its logic are absent.
//
// RD_LATENCY = 1 : standard FIFO, data valid the cycle after the read strobe.
// RD_LATENCY = 0 : first-word-fall-through FIFO.
module conv_puncturer
    import punct_pkg::*;
#(
    parameter int RD_LATENCY = 1,
    parameter int CNT_W      = 16
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic [1:0]       i_rate_sel,
    input  logic [1:0]       i_fifo_dout,
    input  logic             i_fifo_empty,
    output logic             o_fifo_rd_en,
    output logic             o_bit_out,
    output logic             o_bit_valid,
    input  logic             i_bit_ready
`ifdef PUNCT_STATS_EN
    ,
    output logic [CNT_W-1:0] o_dropped_cnt
`endif
);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t             r_state;
    state_t             w_state_next;
    logic [PHASE_W-1:0] r_phase;
    logic [PHASE_W-1:0] w_phase_next;
    logic [1:0]         r_rate_q;
    logic [1:0]         w_rate_q_next;
    logic [1:0]         r_pair;
    logic [1:0]         w_pair_next;

    // Outputs are registered so they are glitch-free and forced low by reset.
    logic               r_fifo_rd_en;
    logic               w_fifo_rd_en_next;
    logic               r_bit_out;
    logic               w_bit_out_next;
    logic               r_bit_valid;
    logic               w_bit_valid_next;

    // Pattern lookup results
    logic [1:0]         w_rate_eff;
    logic               w_keep_a;
    logic               w_keep_b;
    logic               w_last_phase;
    logic               w_handshake;

    // A new period picks up rate_sel in the same LOAD cycle that latches it,
    // so the lookup sees the fresh rate immediately; otherwise the held rate.
    assign w_rate_eff = ((r_state == ST_LOAD) && (r_phase == '0)) ? i_rate_sel : r_rate_q;

    // A bit is consumed only while one of the emit states is presenting it.
    assign w_handshake = i_bit_ready &&
                         ((r_state == ST_EMIT_A) || (r_state == ST_EMIT_B));

    punct_mask u_mask (
        .i_rate       (w_rate_eff),
        .i_phase      (r_phase),
        .o_keep_a     (w_keep_a),
        .o_keep_b     (w_keep_b),
        .o_last_phase (w_last_phase)
    );

    // ------------------------------------------------------------------
    // FSM process 1: state register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM process 2: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                // Only IDLE requests data, so a held pair is never overwritten.
                if (!i_fifo_empty) begin
                    w_state_next = (RD_LATENCY == 0) ? ST_LOAD : ST_WAIT;
                end
            end
            ST_WAIT: begin
                w_state_next = ST_LOAD;
            end
            ST_LOAD: begin
                if (w_keep_a) begin
                    w_state_next = ST_EMIT_A;
                end else if (w_keep_b) begin
                    w_state_next = ST_EMIT_B;
                end else begin
                    w_state_next = ST_ADV;
                end
            end
            ST_EMIT_A: begin
                if (w_handshake) begin
                    w_state_next = w_keep_b ? ST_EMIT_B : ST_ADV;
                end
            end
            ST_EMIT_B: begin
                if (w_handshake) begin
                    w_state_next = ST_ADV;
                end
            end
            ST_ADV: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM process 3: output and datapath next values
    // ------------------------------------------------------------------
    always_comb begin
        // The read strobe is registered, so it is high for the single cycle
        // after IDLE saw data: WAIT for a standard FIFO, LOAD for FWFT.
        w_fifo_rd_en_next = (r_state == ST_IDLE) && !i_fifo_empty;

        w_pair_next   = (r_state == ST_LOAD) ? i_fifo_dout : r_pair;
        w_rate_q_next = w_rate_eff;

        w_phase_next = r_phase;
        if (r_state == ST_ADV) begin
            w_phase_next = w_last_phase ? '0 : (r_phase + 2'd1);
        end

        // Present the bit belonging to the state being entered; while
        // stalled the state and pair hold, so the bit holds too.
        w_bit_valid_next = 1'b0;
        w_bit_out_next   = 1'b0;
        case (w_state_next)
            ST_EMIT_A: begin
                w_bit_valid_next = 1'b1;
                w_bit_out_next   = w_pair_next[1];
            end
            ST_EMIT_B: begin
                w_bit_valid_next = 1'b1;
                w_bit_out_next   = w_pair_next[0];
            end
            default: ;
        endcase
    end

    // Datapath and output registers; reset discards any held pair.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_phase      <= '0;
            r_rate_q     <= RATE_1_2;
            r_pair       <= 2'b00;
            r_fifo_rd_en <= 1'b0;
            r_bit_out    <= 1'b0;
            r_bit_valid  <= 1'b0;
        end else begin
            r_phase      <= w_phase_next;
            r_rate_q     <= w_rate_q_next;
            r_pair       <= w_pair_next;
            r_fifo_rd_en <= w_fifo_rd_en_next;
            r_bit_out    <= w_bit_out_next;
            r_bit_valid  <= w_bit_valid_next;
        end
    end

    assign o_fifo_rd_en = r_fifo_rd_en;
    assign o_bit_out    = r_bit_out;
    assign o_bit_valid  = r_bit_valid;

`ifdef PUNCT_STATS_EN
    // ------------------------------------------------------------------
    // Punctured-bit statistics
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] r_dropped_cnt;
    logic             w_drop_a;
    logic             w_drop_b;
    logic [1:0]       w_drop_num;
    logic [CNT_W:0]   w_cnt_sum;

    // A is dropped when LOAD finds keepA=0. B is dropped when the pair
    // leaves for ADV without B having been emitted.
    assign w_drop_a   = (r_state == ST_LOAD) && !w_keep_a;
    assign w_drop_b   = ((r_state == ST_LOAD) && !w_keep_a && !w_keep_b) ||
                        ((r_state == ST_EMIT_A) && w_handshake && !w_keep_b);
    assign w_drop_num = {1'b0, w_drop_a} + {1'b0, w_drop_b};
    assign w_cnt_sum  = {1'b0, r_dropped_cnt} + {{(CNT_W - 1){1'b0}}, w_drop_num};

    // Saturating counter: sticks at all-ones instead of wrapping.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_dropped_cnt <= '0;
        end else if (w_cnt_sum[CNT_W]) begin
            r_dropped_cnt <= '1;
        end else begin
            r_dropped_cnt <= w_cnt_sum[CNT_W-1:0];
        end
    end

    assign o_dropped_cnt = r_dropped_cnt;
`else
    // Counter width only matters when statistics are built in.
    logic w_unused_cnt_w;
    assign w_unused_cnt_w = (CNT_W > 0);
`endif

endmodule
